// File: rtl/multi_cycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle controller and its
// instruction memory, data memory and datapath.
interface multi_cycle_ctrl_if;
  logic [31:0] instr;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        ir_we;
  logic        pc_we;
  logic [11:0] alu_ctrl;
  logic        alu_src_imm;
  logic        reg_we;

  modport master (
    input  instr, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_ctrl, alu_src_imm, reg_we
  );

  modport slave (
    output instr, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_ctrl, alu_src_imm, reg_we
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for a two-instruction (addiu / sw) subset:
// fetch, decode, execute, memory and write-back sequencing with a sticky trap.
module multi_cycle_ctrl (
  input  logic                   clk,
  input  logic                   rst_n,
  multi_cycle_ctrl_if.master     ctrl_if,
  output logic                   illegal_o,
  output logic [31:0]            retired_o
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 12;
  localparam int unsigned CNT_W = 32;

  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              imem_req_c;
  logic              ir_we_c;
  logic              pc_we_c;
  logic              dmem_req_c;
  logic              dmem_we_c;
  logic              reg_we_c;
  logic              alu_src_imm_c;
  logic [ALU_W-1:0]  alu_ctrl_c;

  // State and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    illegal_d     = illegal_q;
    retired_d     = retired_q;
    imem_req_c    = 1'b0;
    ir_we_c       = 1'b0;
    pc_we_c       = 1'b0;
    dmem_req_c    = 1'b0;
    dmem_we_c     = 1'b0;
    reg_we_c      = 1'b0;
    alu_src_imm_c = 1'b0;
    alu_ctrl_c    = '0;

    unique case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (ctrl_if.imem_ack) begin
          ir_we_c  = 1'b1;
          pc_we_c  = 1'b1;
          opcode_d = ctrl_if.instr[31:26];
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if ((opcode_q == OP_ADDIU) || (opcode_q == OP_SW)) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_ctrl_c    = {opcode_q, 6'b000000};
        alu_src_imm_c = 1'b1;
        state_d       = (opcode_q == OP_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        alu_ctrl_c    = {opcode_q, 6'b000000};
        alu_src_imm_c = 1'b1;
        dmem_req_c    = 1'b1;
        dmem_we_c     = 1'b1;
        if (ctrl_if.dmem_ack) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end
      end
      S_WB: begin
        alu_ctrl_c    = {opcode_q, 6'b000000};
        alu_src_imm_c = 1'b1;
        reg_we_c      = 1'b1;
        retired_d     = retired_q + CNT_W'(1);
        state_d       = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset parks the FSM in FETCH, so the fetch-side strobes are masked by rst_n
  // to keep them low for as long as reset is held.
  assign ctrl_if.imem_req    = imem_req_c & rst_n;
  assign ctrl_if.ir_we       = ir_we_c & rst_n;
  assign ctrl_if.pc_we       = pc_we_c & rst_n;
  assign ctrl_if.dmem_req    = dmem_req_c;
  assign ctrl_if.dmem_we     = dmem_we_c;
  assign ctrl_if.reg_we      = reg_we_c;
  assign ctrl_if.alu_src_imm = alu_src_imm_c;
  assign ctrl_if.alu_ctrl    = alu_ctrl_c;

  assign illegal_o = illegal_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed vector table, hand-written
// reset/wrap/trap sequences and randomized instruction streams with spurious acks.
module tb_multi_cycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic        illegal;
  logic [31:0] retired;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctrl_if   (bus),
    .illegal_o (illegal),
    .retired_o (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [31:0] exp_ret;

  typedef struct {
    logic [31:0] word;
    int          iw;
    int          dw;
    bit          spur;
    int          exp_lat;
    int          exp_reg;
    int          exp_dm;
    logic [11:0] exp_alu;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // Observation vector {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, alu_src_imm, alu_ctrl}
  function automatic logic [18:0] ex(input logic im, input logic ir, input logic dm,
                                     input logic rw, input logic src, input logic [11:0] alu);
    return {im, dm, dm, ir, ir, rw, src, alu};
  endfunction

  function automatic logic [18:0] act();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we,
            bus.reg_we, bus.alu_src_imm, bus.alu_ctrl};
  endfunction

  // Builds the expected per-cycle trace of one instruction from its type and
  // wait counts, drives the memories accordingly and measures latency.
  task automatic run_instr(input logic [31:0] word, input int iw, input int dw, input bit spur,
                           output int lat, output int reg_cnt, output int dm_cnt,
                           output logic [11:0] alu_max);
    logic [18:0] q[$];
    logic [5:0]  op;
    logic [11:0] alu;
    bit          is_sw;
    int          mem_start;
    int          last;
    op    = word[31:26];
    alu   = {op, 6'b000000};
    is_sw = (op == 6'b101011);
    for (int i = 0; i < iw; i++) q.push_back(ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000));
    q.push_back(ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000));
    q.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000));
    q.push_back(ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, alu));
    mem_start = q.size();
    if (is_sw) begin
      for (int i = 0; i <= dw; i++) q.push_back(ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, alu));
    end else begin
      q.push_back(ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, alu));
    end
    q.push_back(ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000));
    last    = q.size() - 1;
    lat     = -1;
    reg_cnt = 0;
    dm_cnt  = 0;
    alu_max = 12'h000;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == iw)                  bus.imem_ack = 1'b1;
      else if (k > iw && k < last)  bus.imem_ack = spur ? 1'($urandom) : 1'b0;
      else                          bus.imem_ack = 1'b0;
      bus.instr = (k == iw) ? word : $urandom;
      if (is_sw && k >= mem_start && k < last) bus.dmem_ack = (k == last - 1);
      else                                     bus.dmem_ack = spur ? 1'($urandom) : 1'b0;
      #1;
      chk("cycle_outputs", 32'(act()), 32'(q[k]));
      chk("retired", retired, exp_ret);
      chk("illegal_low", 32'(illegal), 32'd0);
      if (lat < 0 && k > iw && bus.imem_req) lat = k;
      if (bus.reg_we) reg_cnt++;
      if (bus.dmem_req) dm_cnt++;
      if (bus.alu_ctrl > alu_max) alu_max = bus.alu_ctrl;
      if (k == last - 1) exp_ret = exp_ret + 32'd1;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    int          lat;
    int          rc;
    int          dc;
    logic [11:0] am;
    logic [31:0] w;
    int          iw;
    int          dw;
    bit          sw;

    vecs[0] = '{32'h24010005, 0, 0, 1'b0, 4, 1, 0, 12'h240};
    vecs[1] = '{32'hAC220004, 0, 3, 1'b0, 7, 0, 4, 12'hAC0};
    vecs[2] = '{32'h24A3FFFF, 2, 0, 1'b1, 6, 1, 0, 12'h240};
    vecs[3] = '{32'hAC220004, 1, 1, 1'b1, 6, 0, 2, 12'hAC0};
    vecs[4] = '{32'hAFFFFFFF, 0, 0, 1'b1, 4, 0, 1, 12'hAC0};
    vecs[5] = '{32'h27FF8000, 3, 2, 1'b1, 7, 1, 0, 12'h240};

    checks       = 0;
    errors       = 0;
    exp_ret      = 32'd0;
    rst_n        = 1'b0;
    bus.instr    = 32'h0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;

    // Reset state, including a stray imem_ack while reset is held
    #3;
    chk("rst_outputs", 32'(act()), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_retired", retired, 32'd0);
    bus.imem_ack = 1'b1;
    bus.instr    = 32'h24010005;
    #1;
    chk("rst_ack_masked", 32'(act()), 32'd0);
    bus.imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_imem_req", 32'(bus.imem_req), 32'd1);
    @(posedge clk);
    #1;
    chk("first_edge_imem_req", 32'(bus.imem_req), 32'd1);

    // Directed vector table
    for (int v = 0; v < 6; v++) begin
      run_instr(vecs[v].word, vecs[v].iw, vecs[v].dw, vecs[v].spur, lat, rc, dc, am);
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      chk($sformatf("vec%0d_reg_we", v), 32'(rc), 32'(vecs[v].exp_reg));
      chk($sformatf("vec%0d_dmem_cycles", v), 32'(dc), 32'(vecs[v].exp_dm));
      chk($sformatf("vec%0d_alu_ctrl", v), 32'(am), 32'(vecs[v].exp_alu));
    end

    // Asynchronous reset in the middle of a stalled store
    @(negedge clk);
    bus.imem_ack = 1'b1;
    bus.instr    = 32'hAC220004;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mem_dmem_req", 32'(bus.dmem_req), 32'd1);
    chk("mem_retired_before", retired, exp_ret);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 32'(act()), 32'd0);
    chk("async_rst_retired", retired, 32'd0);
    exp_ret = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rerelease_imem_req", 32'(bus.imem_req), 32'd1);
    @(posedge clk);
    #1;
    chk("rerelease_edge_imem_req", 32'(bus.imem_req), 32'd1);
    chk("rerelease_retired", retired, 32'd0);

    // Counter wrap from all-ones
    #2;
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    exp_ret = 32'hFFFF_FFFF;
    run_instr(32'h24010005, 0, 0, 1'b1, lat, rc, dc, am);
    chk("wrap_retired", retired, 32'd0);
    chk("wrap_latency", 32'(lat), 32'd4);

    // Randomized legal instruction stream with random waits and spurious acks
    for (int n = 0; n < 150; n++) begin
      sw = 1'($urandom);
      w  = $urandom;
      w[31:26] = sw ? 6'b101011 : 6'b001001;
      iw = int'($urandom_range(0, 3));
      dw = int'($urandom_range(0, 3));
      run_instr(w, iw, dw, 1'b1, lat, rc, dc, am);
      chk("rand_latency", 32'(lat), 32'(4 + iw + (sw ? dw : 0)));
      chk("rand_alu_ctrl", 32'(am), 32'({w[31:26], 6'b000000}));
    end
    chk("rand_retired_total", retired, 32'd150);

    // Unsupported opcode traps permanently
    @(negedge clk);
    bus.imem_ack = 1'b1;
    bus.instr    = 32'h00000000;
    #1;
    chk("trap_fetch", 32'(act()), 32'(ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000)));
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.instr    = $urandom;
    #1;
    chk("trap_decode_outputs", 32'(act()), 32'd0);
    chk("trap_decode_illegal", 32'(illegal), 32'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.imem_ack = 1'($urandom);
      bus.dmem_ack = 1'($urandom);
      bus.instr    = $urandom;
      #1;
      chk("trap_outputs", 32'(act()), 32'd0);
      chk("trap_illegal", 32'(illegal), 32'd1);
      chk("trap_retired", retired, exp_ret);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 clk  input  1  rising-edge system clock; one clock domain.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 instr  input  32  instruction word from instruction memory; valid only while imem_ack=1.
REQ-004 imem_req  output  1  instruction fetch request.
REQ-005 imem_ack  input  1  instruction memory acknowledge.
REQ-006 dmem_req  output  1  data memory access request.
REQ-007 dmem_we  output  1  data memory write strobe; valid only with dmem_req.
REQ-008 dmem_ack  input  1  data memory acknowledge.
REQ-009 ir_we  output  1  one-cycle load strobe for the external instruction register.
REQ-010 pc_we  output  1  one-cycle PC advance strobe (PC <= PC+4).
REQ-011 alu_ctrl  output  12  ALU operation code {opcode[5:0], 6'b000000}.
REQ-012 alu_src_imm  output  1  ALU src2 select: 1 = sign-extended instr[15:0], 0 = register rt.
REQ-013 reg_we  output  1  register file write strobe, destination rt.
REQ-014 illegal  output  1  sticky flag: unsupported opcode decoded.
REQ-015 retired  output  32  count of retired instructions.

Function
REQ-016 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; encoding is free.
REQ-017 FETCH: imem_req=1 held until imem_ack=1. On ack cycle: ir_we=1 and pc_we=1 (combinational, same cycle), internal opcode register <= instr[31:26], next state DECODE.
REQ-018 imem_req SHALL NOT deassert before imem_ack. imem_ack arriving while imem_req=0 SHALL be ignored.
REQ-019 DECODE (1 cycle): opcode 6'b001001 (addiu) or 6'b101011 (sw) -> EXEC. Any other opcode -> TRAP, with illegal set on the transition.
REQ-020 EXEC (1 cycle): alu_ctrl={opcode,6'b0} and alu_src_imm=1. Next state is WB for addiu, MEM for sw.
REQ-021 MEM: dmem_req=1 and dmem_we=1 held until dmem_ack=1; alu_ctrl and alu_src_imm held at EXEC values. On ack: retired increments, next state FETCH.
REQ-022 WB (1 cycle): reg_we=1; alu_ctrl and alu_src_imm held; retired increments; next state FETCH.
REQ-023 Outside EXEC, MEM and WB, alu_ctrl SHALL be 12'h000 and alu_src_imm SHALL be 0.
REQ-024 Outside their own states, strobes SHALL be 0: ir_we, pc_we, reg_we, dmem_req, dmem_we, imem_req.
REQ-025 TRAP is terminal until reset: all requests and strobes are 0, illegal=1, retired is frozen.
REQ-026 retired SHALL wrap from 32'hFFFFFFFF to 0 without any flag.
REQ-027 Minimum latency with zero-wait acks is 4 cycles per instruction for both addiu and sw. Each wait cycle on imem_ack or dmem_ack adds exactly 1 cycle.
REQ-028 dmem_ack seen outside MEM and imem_ack seen outside FETCH SHALL have no effect.

Reset
REQ-029 While rst_n=0, outputs SHALL be forced immediately, independent of clk: state=FETCH, opcode register=0, illegal=0, retired=0, all strobes and requests 0, alu_ctrl=0.
REQ-030 On the first rising clk edge after rst_n deasserts, imem_req=1.
REQ-031 Reset asserted mid-MEM or mid-FETCH SHALL drop dmem_req and imem_req within the same cycle. The interrupted instruction SHALL NOT be counted.

Verification
REQ-032 Single addiu, zero-wait: instr=32'h24010005 with imem_ack on the first FETCH cycle -> ir_we=pc_we=1 in cycle 0; alu_ctrl=12'h240 in cycles 2-3; reg_we=1 in cycle 3; retired=1; imem_req=1 in cycle 4.
REQ-033 sw with 3-cycle dmem wait: instr=32'hAC220004 -> dmem_req=dmem_we=1 for 4 cycles; alu_ctrl=12'hAC0 throughout MEM; reg_we stays 0; retired increments only on the ack cycle.
REQ-034 Illegal opcode: instr=32'h00000000 -> illegal=1 after DECODE; all requests stay 0 for 20 following cycles; retired unchanged.
REQ-035 Async reset mid-MEM: rst_n low between clock edges -> dmem_req=0 before the next edge; retired=0; after release imem_req=1 on the first edge.
REQ-036 Wrap and spurious acks: preload retired to 32'hFFFFFFFF via 2^32-1 retirements (or a forced initial value) -> next retirement gives retired=0. dmem_ack pulsed during FETCH causes no state change.
